// File: rtl/playfield_engine.sv
`default_nettype none
// ============================================================================
// Module   : playfield_engine
// Brief    : Settles four-cell pieces onto a bitmap playfield, clears full
//            rows bottom-up and accumulates a saturating score.
// Revision : 1.0
// ============================================================================
module playfield_engine #(
    parameter int COLS    = 8,
    parameter int ROWS    = 16,
    parameter int XW      = 3,
    parameter int YW      = 4,
    parameter int SCORE_W = 10
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   restart,
    input  logic                   lock_valid,
    output logic                   lock_ready,
    input  logic [4*XW-1:0]        piece_x,
    input  logic [4*YW-1:0]        piece_y,
    output logic [ROWS*COLS-1:0]   map,
    output logic                   done,
    output logic [2:0]             lines_delta,
    output logic [SCORE_W-1:0]     score,
    output logic                   game_over
);

    localparam int c_CELLS = ROWS * COLS;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        SHIFT = 3'd2,
        DONE  = 3'd3,
        OVER  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CELLS-1:0]   r_map;
    logic [YW-1:0]        r_row;
    logic [2:0]           r_count;
    logic                 r_done;
    logic [2:0]           r_lines_delta;
    logic [SCORE_W-1:0]   r_score;
    logic                 r_game_over;

    logic [c_CELLS-1:0]   w_piece;
    logic                 w_oob;
    logic                 w_hit;
    logic                 w_accept;
    logic [COLS-1:0]      w_row_bits;
    logic                 w_row_full;
    logic [c_CELLS-1:0]   w_shifted;
    logic [3:0]           w_pts;
    logic [SCORE_W:0]     w_sum;
    logic [SCORE_W-1:0]   w_score_next;

    // Piece footprint; out-of-range cells are flagged instead of placed.
    always_comb begin
        int px;
        int py;
        w_piece = '0;
        w_oob   = 1'b0;
        px      = 0;
        py      = 0;
        for (int k = 0; k < 4; k++) begin
            px = int'(piece_x[k*XW +: XW]);
            py = int'(piece_y[k*YW +: YW]);
            if (px >= COLS || py >= ROWS) begin
                w_oob = 1'b1;
            end else begin
                w_piece[py*COLS + px] = 1'b1;
            end
        end
    end

    assign w_hit      = w_oob | (|(w_piece & r_map));
    assign lock_ready = (r_state == IDLE);
    assign w_accept   = lock_valid & lock_ready;

    assign w_row_bits = r_map[int'(r_row)*COLS +: COLS];
    assign w_row_full = &w_row_bits;

    // Rows above the pointer drop by one; the top row always empties.
    always_comb begin
        w_shifted = r_map;
        for (int y = 1; y < ROWS; y++) begin
            if (y <= int'(r_row)) begin
                w_shifted[y*COLS +: COLS] = r_map[(y-1)*COLS +: COLS];
            end
        end
        w_shifted[0 +: COLS] = '0;
    end

    always_comb begin
        case (r_count)
            3'd0:    w_pts = 4'd0;
            3'd1:    w_pts = 4'd1;
            3'd2:    w_pts = 4'd3;
            3'd3:    w_pts = 4'd5;
            default: w_pts = 4'd8;
        endcase
    end

    assign w_sum        = {1'b0, r_score} + (SCORE_W+1)'(w_pts);
    assign w_score_next = w_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = w_hit ? OVER : SCAN;
                end
            end
            SCAN: begin
                if (w_row_full) begin
                    w_state_next = SHIFT;
                end else if (r_row == '0) begin
                    w_state_next = DONE;
                end
            end
            SHIFT:   w_state_next = SCAN;
            DONE:    w_state_next = IDLE;
            OVER:    w_state_next = OVER;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset || restart) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset || restart) begin
            r_map         <= '0;
            r_row         <= '0;
            r_count       <= '0;
            r_done        <= 1'b0;
            r_lines_delta <= '0;
            r_score       <= '0;
            r_game_over   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_hit) begin
                            r_game_over <= 1'b1;
                        end else begin
                            r_map   <= r_map | w_piece;
                            r_row   <= YW'(ROWS-1);
                            r_count <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (!w_row_full && r_row != '0) begin
                        r_row <= r_row - YW'(1);
                    end
                end
                SHIFT: begin
                    r_map <= w_shifted;
                    if (r_count != 3'd4) begin
                        r_count <= r_count + 3'd1;
                    end
                end
                DONE: begin
                    r_done        <= 1'b1;
                    r_lines_delta <= r_count;
                    r_score       <= w_score_next;
                end
                default: ;
            endcase
        end
    end

    assign map         = r_map;
    assign done        = r_done;
    assign lines_delta = r_lines_delta;
    assign score       = r_score;
    assign game_over   = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_playfield_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_playfield_engine
// Brief    : Directed vector bench for playfield_engine (default build plus a
//            wide-x, 4-bit-score build).
// Revision : 1.0
// ============================================================================
module tb_playfield_engine;

    logic          CLK = 1'b0;
    logic          reset;
    logic          restart, restart_s;
    logic          lv, lv_s;
    logic [11:0]   px;
    logic [15:0]   py;
    logic [15:0]   px_s, py_s;

    logic          lock_ready, done, game_over;
    logic [127:0]  map;
    logic [2:0]    lines_delta;
    logic [9:0]    score;

    logic          lock_ready_s, done_s, game_over_s;
    logic [127:0]  map_s;
    logic [2:0]    lines_delta_s;
    logic [3:0]    score_s;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    playfield_engine dut (
        .CLK(CLK), .reset(reset), .restart(restart), .lock_valid(lv),
        .lock_ready(lock_ready), .piece_x(px), .piece_y(py), .map(map),
        .done(done), .lines_delta(lines_delta), .score(score), .game_over(game_over)
    );

    playfield_engine #(.COLS(8), .ROWS(16), .XW(4), .YW(4), .SCORE_W(4)) dut_s (
        .CLK(CLK), .reset(reset), .restart(restart_s), .lock_valid(lv_s),
        .lock_ready(lock_ready_s), .piece_x(px_s), .piece_y(py_s), .map(map_s),
        .done(done_s), .lines_delta(lines_delta_s), .score(score_s), .game_over(game_over_s)
    );

    typedef struct {
        logic [15:0]  xs;
        logic [15:0]  ys;
        int           lat;
        logic [2:0]   ld;
        logic [9:0]   sc;
        bit           clr;
        logic [127:0] map;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] cell_mask(input logic [15:0] xs, input logic [15:0] ys);
        logic [127:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[int'(ys[k*4 +: 4])*8 + int'(xs[k*4 +: 4])] = 1'b1;
        end
        return m;
    endfunction

    // Presents one lock and returns cycles from the accepting edge to done.
    task automatic do_lock(input bit sel, input logic [15:0] xs, input logic [15:0] ys,
                           output int lat);
        @(negedge CLK);
        if (sel) begin
            px_s = xs;
            py_s = ys;
            lv_s = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) px[k*3 +: 3] = xs[k*4 +: 3];
            py = ys;
            lv = 1'b1;
        end
        @(posedge CLK);
        #1;
        lv   = 1'b0;
        lv_s = 1'b0;
        lat  = 0;
        while (lat < 100) begin
            if (sel ? done_s : done) break;
            @(posedge CLK);
            #1;
            lat++;
        end
    endtask

    initial begin
        int            lat;
        int            done_seen;
        logic [127:0]  exp_map;
        logic [3:0]    cn;

        reset = 1'b0; restart = 1'b0; restart_s = 1'b0;
        lv = 1'b0; lv_s = 1'b0; px = '0; py = '0; px_s = '0; py_s = '0;

        tbl[0] = '{16'h3210, 16'hFFFF, 17, 3'd0, 10'd0, 1'b0, 128'd0};
        tbl[1] = '{16'h7654, 16'hFFFF, 19, 3'd1, 10'd1, 1'b1, 128'd0};
        for (int c = 0; c < 7; c++) begin
            cn = 4'(c);
            tbl[2+c] = '{{4{cn}}, 16'hFEDC, 17, 3'd0, 10'd1, 1'b0, 128'd0};
        end
        tbl[9]  = '{16'h0000, 16'hBBBB, 17, 3'd0, 10'd1, 1'b0, 128'd0};
        tbl[10] = '{16'h7777, 16'hFEDC, 25, 3'd4, 10'd9, 1'b1, 128'd1 << 120};

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        check("reset_map", map, 128'd0);
        check("reset_score", 128'(score), 128'd0);
        check("reset_game_over", 128'(game_over), 128'd0);
        check("reset_lock_ready", 128'(lock_ready), 128'd1);
        check("reset_done", 128'(done), 128'd0);
        check("reset_lines_delta", 128'(lines_delta), 128'd0);

        exp_map = '0;
        for (int i = 0; i < 11; i++) begin
            do_lock(1'b0, tbl[i].xs, tbl[i].ys, lat);
            exp_map = tbl[i].clr ? tbl[i].map : (exp_map | cell_mask(tbl[i].xs, tbl[i].ys));
            check($sformatf("v%0d_latency", i), 128'(lat), 128'(tbl[i].lat));
            check($sformatf("v%0d_lines_delta", i), 128'(lines_delta), 128'(tbl[i].ld));
            check($sformatf("v%0d_score", i), 128'(score), 128'(tbl[i].sc));
            check($sformatf("v%0d_map", i), map, exp_map);
            @(posedge CLK);
            #1;
            check($sformatf("v%0d_done_pulse", i), 128'(done), 128'd0);
        end

        // Lock onto the occupied marker cell.
        @(negedge CLK);
        px = 12'h688; py = 16'hFFFF; lv = 1'b1;
        @(posedge CLK);
        #1;
        lv = 1'b0;
        check("coll_game_over", 128'(game_over), 128'd1);
        check("coll_lock_ready", 128'(lock_ready), 128'd0);
        check("coll_map", map, 128'd1 << 120);
        @(negedge CLK);
        px = 12'h249; py = 16'h0000; lv = 1'b1;
        repeat (3) @(negedge CLK);
        lv = 1'b0;
        check("over_map", map, 128'd1 << 120);
        check("over_game_over", 128'(game_over), 128'd1);
        check("over_lock_ready", 128'(lock_ready), 128'd0);
        restart = 1'b1;
        @(posedge CLK);
        #1;
        restart = 1'b0;
        check("restart_map", map, 128'd0);
        check("restart_score", 128'(score), 128'd0);
        check("restart_game_over", 128'(game_over), 128'd0);
        check("restart_lock_ready", 128'(lock_ready), 128'd1);
        check("restart_lines_delta", 128'(lines_delta), 128'd0);

        // Abort mid-scan, with a lock attempt while busy that must be ignored.
        @(negedge CLK);
        px = 12'h688; py = 16'hFFFF; lv = 1'b1;
        @(posedge CLK);
        #1;
        px = 12'h000; py = 16'h0000;
        repeat (3) @(negedge CLK);
        lv = 1'b0;
        check("busy_ignore_map", map, 128'hF << 120);
        restart = 1'b1;
        @(posedge CLK);
        #1;
        restart = 1'b0;
        check("abort_map", map, 128'd0);
        check("abort_score", 128'(score), 128'd0);
        check("abort_lock_ready", 128'(lock_ready), 128'd1);
        done_seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK);
            #1;
            if (done) done_seen++;
        end
        check("abort_no_done", 128'(done_seen), 128'd0);

        // Wide-x build: x=8 is out of range.
        @(negedge CLK);
        px_s = 16'h8210; py_s = 16'hFFFF; lv_s = 1'b1;
        @(posedge CLK);
        #1;
        lv_s = 1'b0;
        check("oob_game_over", 128'(game_over_s), 128'd1);
        check("oob_map", map_s, 128'd0);
        check("oob_lock_ready", 128'(lock_ready_s), 128'd0);
        @(negedge CLK);
        restart_s = 1'b1;
        @(negedge CLK);
        restart_s = 1'b0;
        check("oob_restart_ready", 128'(lock_ready_s), 128'd1);

        // Three quad clears into a 4-bit score: 8, then saturate at 15.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 7; c++) begin
                cn = 4'(c);
                do_lock(1'b1, {4{cn}}, 16'hFEDC, lat);
            end
            do_lock(1'b1, 16'h7777, 16'hFEDC, lat);
            check($sformatf("sat%0d_latency", r), 128'(lat), 128'd25);
            check($sformatf("sat%0d_lines_delta", r), 128'(lines_delta_s), 128'd4);
            check($sformatf("sat%0d_score", r), 128'(score_s), (r == 0) ? 128'd8 : 128'd15);
            check($sformatf("sat%0d_map", r), map_s, 128'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
